mcycle_alu_seq: RTL and testbench

- Multi-cycle sequencer that runs 32-step unsigned multiply (shift-add) and divide (restoring) on the core's shared 32-bit ALU. It does not instantiate its own adder.
- Sits beside the execute stage. While Busy, it takes ownership of the ALU input mux through AluOwn, and the pipeline stalls on Busy.
- Drives ALU operands and control each cycle and consumes AluResult/AluFlags combinationally in the same cycle.

---
 rtl/mcycle_pkg.sv | 47 ++++
 rtl/mcycle_step_dp.sv | 111 +++++++++++
 rtl/mcycle_alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_mcycle_alu_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// op encodings, ALU control codes, FSM states and datapath commands.
package mcycle_pkg;

    localparam logic [1:0] MCYC_MULU = 2'b00;
    localparam logic [1:0] MCYC_MUL  = 2'b01;
    localparam logic [1:0] MCYC_DIVU = 2'b10;
    localparam logic [1:0] MCYC_DIV  = 2'b11;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0001;
    localparam logic [3:0] ALUC_XOR = 4'b1000;

    localparam int ITER_LAST = 31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_A,
        S_PRE_B,
        S_COMPUTE,
        S_POST_1,
        S_POST_2,
        S_POST_3,
        S_DONE
    } state_t;

    // What the step datapath does with the shared ALU this cycle.
    typedef enum logic [2:0] {
        DP_HOLD,
        DP_LOAD,
        DP_STEP,
        DP_NEG_LO,
        DP_NEG_M,
        DP_NEG_HI,
        DP_INV_HI,
        DP_INC_HI
    } dp_cmd_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MCYC_DIVU) || (op == MCYC_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MCYC_MUL) || (op == MCYC_DIV);
    endfunction

endpackage

// File: rtl/mcycle_step_dp.sv
// Working registers (hi/rem, lo/quo, operand m, negate carry z) and the
// per-command ALU operand selection and register update muxing.
module mcycle_step_dp
    import mcycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  dp_cmd_t         cmd,
    input  logic            we,
    input  logic            is_div,
    input  logic [XLEN-1:0] load_lo,
    input  logic [XLEN-1:0] load_m,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_eq,
    input  logic            alu_ltu,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] hi_d,
    output logic [XLEN-1:0] lo_d,
    output logic            lo_msb,
    output logic            m_msb,
    output logic            m_zero
);
    logic [XLEN-1:0] hi_q, lo_q, m_q, m_d, sh;
    logic            z_q, z_d, qbit;

    assign sh     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign lo_msb = lo_q[XLEN-1];
    assign m_msb  = m_q[XLEN-1];
    assign m_zero = (m_q == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        z_d   = z_q;
        alu_a = '0;
        alu_b = '0;
        qbit  = 1'b0;
        unique case (cmd)
            DP_LOAD: begin
                hi_d = '0;
                lo_d = load_lo;
                m_d  = load_m;
            end
            DP_STEP: begin
                if (is_div) begin
                    // Subtract succeeds when the shifted-out top bit is set or no borrow occurred.
                    alu_a = sh;
                    alu_b = m_q;
                    qbit  = hi_q[XLEN-1] | ~alu_ltu;
                    hi_d  = qbit ? alu_result : sh;
                    lo_d  = {lo_q[XLEN-2:0], qbit};
                end else begin
                    alu_a        = hi_q;
                    alu_b        = lo_q[0] ? m_q : '0;
                    {hi_d, lo_d} = {~alu_ltu, alu_result, lo_q[XLEN-1:1]};
                end
            end
            DP_NEG_LO: begin
                alu_b = lo_q;
                lo_d  = alu_result;
                z_d   = alu_eq;
            end
            DP_NEG_M: begin
                alu_b = m_q;
                m_d   = alu_result;
            end
            DP_NEG_HI: begin
                alu_b = hi_q;
                hi_d  = alu_result;
            end
            DP_INV_HI: begin
                alu_a = hi_q;
                alu_b = '1;
                hi_d  = alu_result;
            end
            DP_INC_HI: begin
                alu_a = hi_q;
                alu_b = {{(XLEN-1){1'b0}}, z_q};
                hi_d  = alu_result;
            end
            default: ;
        endcase
        if (!we) begin
            hi_d = hi_q;
            lo_d = lo_q;
            m_d  = m_q;
            z_d  = z_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
            z_q  <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q  <= m_d;
            z_q  <= z_d;
        end
    end

endmodule

// File: rtl/mcycle_alu_seq.sv
// Multi-cycle multiply/divide sequencer driving the core's shared ALU.
// Define MCYCLE_SIGNED_EN to add signed MUL/DIV via pre/post sign fix-up states.
module mcycle_alu_seq
    import mcycle_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            Start,
    input  logic [1:0]      MCycleOp,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    output logic [XLEN-1:0] Result1,
    output logic [XLEN-1:0] Result2,
    output logic            Busy,
    output logic            Done,
    output logic            AluOwn,
    output logic [XLEN-1:0] AluSrcA,
    output logic [XLEN-1:0] AluSrcB,
    output logic [3:0]      AluControl,
    input  logic [XLEN-1:0] AluResult,
    input  logic [2:0]      AluFlags
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q, accept, finish, load_div;
    dp_cmd_t          dp_cmd;
    logic             dp_we;
    logic [XLEN-1:0]  hi_d, lo_d;
    logic             lo_msb, m_msb, m_zero;
    logic             flags_unused;

    assign flags_unused = AluFlags[1];
    assign accept       = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign load_div     = op_is_div(MCycleOp);

`ifdef MCYCLE_SIGNED_EN
    logic sgn_q, neg_q, rem_neg_q;
    localparam state_t FIRST_STATE = S_PRE_A;
`else
    logic status_unused;
    assign status_unused = lo_msb ^ m_msb ^ m_zero;
    localparam state_t FIRST_STATE = S_COMPUTE;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            Result1   <= '0;
            Result2   <= '0;
`ifdef MCYCLE_SIGNED_EN
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == S_COMPUTE) ? cnt_q + CNT_W'(1) : '0;
            if (accept) begin
                div_q     <= load_div;
`ifdef MCYCLE_SIGNED_EN
                sgn_q     <= op_is_signed(MCycleOp);
                neg_q     <= op_is_signed(MCycleOp) & (Operand1[XLEN-1] ^ Operand2[XLEN-1]);
                rem_neg_q <= op_is_signed(MCycleOp) & Operand1[XLEN-1];
`endif
            end
            // Capture the post-update values so results appear together with Done.
            if (finish) begin
                Result1 <= lo_d;
                Result2 <= hi_d;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dp_cmd     = DP_HOLD;
        dp_we      = 1'b0;
        Busy       = 1'b0;
        AluControl = ALUC_ADD;
        finish     = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = FIRST_STATE;
                    dp_cmd  = DP_LOAD;
                    dp_we   = 1'b1;
                end
            end
            S_COMPUTE: begin
                Busy       = 1'b1;
                dp_cmd     = DP_STEP;
                dp_we      = 1'b1;
                AluControl = div_q ? ALUC_SUB : ALUC_ADD;
                if (cnt_q == CNT_W'(ITER_LAST)) begin
`ifdef MCYCLE_SIGNED_EN
                    state_d = S_POST_1;
`else
                    state_d = S_DONE;
                    finish  = 1'b1;
`endif
                end
            end
`ifdef MCYCLE_SIGNED_EN
            // Operands are still raw here, so their MSB is their sign.
            S_PRE_A: begin
                Busy       = 1'b1;
                AluControl = ALUC_SUB;
                dp_cmd     = DP_NEG_LO;
                dp_we      = sgn_q & lo_msb;
                state_d    = S_PRE_B;
            end
            S_PRE_B: begin
                Busy       = 1'b1;
                AluControl = ALUC_SUB;
                dp_cmd     = DP_NEG_M;
                dp_we      = sgn_q & m_msb;
                state_d    = S_COMPUTE;
            end
            S_POST_1: begin
                Busy       = 1'b1;
                AluControl = ALUC_SUB;
                dp_cmd     = DP_NEG_LO;
                dp_we      = neg_q & (~div_q | ~m_zero);
                state_d    = S_POST_2;
            end
            S_POST_2: begin
                Busy    = 1'b1;
                state_d = S_POST_3;
                if (div_q) begin
                    AluControl = ALUC_SUB;
                    dp_cmd     = DP_NEG_HI;
                    dp_we      = rem_neg_q;
                end else begin
                    AluControl = ALUC_XOR;
                    dp_cmd     = DP_INV_HI;
                    dp_we      = neg_q;
                end
            end
            S_POST_3: begin
                Busy    = 1'b1;
                finish  = 1'b1;
                state_d = S_DONE;
                if (!div_q) begin
                    dp_cmd = DP_INC_HI;
                    dp_we  = neg_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign Done   = (state_q == S_DONE);
    assign AluOwn = Busy;

    mcycle_step_dp #(.XLEN(XLEN)) u_dp (
        .clk       (CLK),
        .reset     (RESET),
        .cmd       (dp_cmd),
        .we        (dp_we),
        .is_div    (div_q),
        .load_lo   (load_div ? Operand1 : Operand2),
        .load_m    (load_div ? Operand2 : Operand1),
        .alu_result(AluResult),
        .alu_eq    (AluFlags[2]),
        .alu_ltu   (AluFlags[0]),
        .alu_a     (AluSrcA),
        .alu_b     (AluSrcB),
        .hi_d      (hi_d),
        .lo_d      (lo_d),
        .lo_msb    (lo_msb),
        .m_msb     (m_msb),
        .m_zero    (m_zero)
    );

endmodule

// File: tb/tb_mcycle_alu_seq.sv
// Bench for mcycle_alu_seq: provides the shared ALU, a cycle-level reference
// model with per-cycle comparison, and directed vectors with literal results.
module tb_mcycle_alu_seq;
`ifdef MCYCLE_SIGNED_EN
    localparam int LAT = 38;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        RESET, Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1, Operand2, Result1, Result2;
    logic        Busy, Done, AluOwn;
    logic [31:0] AluSrcA, AluSrcB, AluResult;
    logic [3:0]  AluControl;
    logic [2:0]  AluFlags;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mcycle_alu_seq #(.XLEN(32), .CNT_W(5)) dut (
        .CLK(clk), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
        .Busy(Busy), .Done(Done), .AluOwn(AluOwn), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluControl(AluControl), .AluResult(AluResult), .AluFlags(AluFlags)
    );

    // Shared core ALU: ADD 0000, SUB 0001, XOR 1000; flags {eq, lt, ltu}, ltu = no carry-out.
    logic [32:0] alu_sum;
    assign alu_sum   = (AluControl == 4'b0001) ? ({1'b0, AluSrcA} + {1'b0, ~AluSrcB} + 33'd1)
                                               : ({1'b0, AluSrcA} + {1'b0, AluSrcB});
    assign AluResult = (AluControl == 4'b1000) ? (AluSrcA ^ AluSrcB) : alu_sum[31:0];
    assign AluFlags  = {AluResult == 32'd0, $signed(AluSrcA) < $signed(AluSrcB), ~alu_sum[32]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {Result2, Result1} of one operation.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic signed [31:0] sa, sb;
        logic signed [63:0] sp;
`ifdef MCYCLE_SIGNED_EN
        sgn = op[0];
`else
        sgn = 1'b0;
`endif
        sa = a;
        sb = b;
        if (!op[1]) begin
            if (sgn) begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Cycle-level model: phase = cycles since the accepted Start (0 = idle).
    int          m_phase = 0;
    logic [31:0] m_res1 = '0, m_res2 = '0, m_pend1 = '0, m_pend2 = '0;
    logic        m_div = 1'b0;

    always @(posedge clk) begin
        if (RESET) begin
            m_phase <= 0;
            m_res1  <= '0;
            m_res2  <= '0;
        end else if ((m_phase == 0 || m_phase == LAT) && Start) begin
            m_phase            <= 1;
            {m_pend2, m_pend1} <= model(MCycleOp, Operand1, Operand2);
            m_div              <= MCycleOp[1];
        end else if (m_phase >= 1 && m_phase < LAT) begin
            m_phase <= m_phase + 1;
            if (m_phase == LAT - 1) begin
                m_res1 <= m_pend1;
                m_res2 <= m_pend2;
            end
        end else begin
            m_phase <= 0;
        end
    end

    logic exp_busy;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_busy = (m_phase >= 1 && m_phase < LAT);
            check("cyc_busy", 32'(Busy), 32'(exp_busy));
            check("cyc_done", 32'(Done), 32'(m_phase == LAT));
            check("cyc_aluown", 32'(AluOwn), 32'(exp_busy));
            check("cyc_result1", Result1, m_res1);
            check("cyc_result2", Result2, m_res2);
            if (!exp_busy) begin
                check("cyc_srca_idle", AluSrcA, 32'd0);
                check("cyc_srcb_idle", AluSrcB, 32'd0);
                check("cyc_ctrl_idle", 32'(AluControl), 32'd0);
            end
`ifndef MCYCLE_SIGNED_EN
            else check("cyc_ctrl_busy", 32'(AluControl), m_div ? 32'd1 : 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (cycle 0), wait for Done, check latency and literal results.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2);
        int cyc;
        int own;
        own      = 0;
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        tick();
        Start = 1'b0;
        cyc   = 1;
        while (Done !== 1'b1 && cyc < LAT + 20) begin
            own += (AluOwn === 1'b1) ? 1 : 0;
            tick();
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'(LAT));
        check({name, "_result1"}, Result1, e1);
        check({name, "_result2"}, Result2, e2);
        check({name, "_aluown_cycles"}, 32'(own), 32'(LAT - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dones;
        RESET    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_aluown", 32'(AluOwn), 32'd0);
        check("rst_result1", Result1, 32'd0);
        check("rst_result2", Result2, 32'd0);
        check("rst_srca", AluSrcA, 32'd0);
        check("rst_srcb", AluSrcB, 32'd0);
        check("rst_ctrl", 32'(AluControl), 32'd0);
        RESET = 1'b0;
        tick();

        run_op("mulu_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 32'h0000_0000);
        tick();
        run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        // Issued in the DONE cycle of the previous operation.
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
        tick();
        run_op("divu_big", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        tick();
        run_op("divu_by0", 2'b10, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234);
        tick();
        run_op("mulu_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
        tick();
        run_op("divu_f_10", 2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F);
        tick();
`ifdef MCYCLE_SIGNED_EN
        run_op("mul_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
        tick();
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        tick();
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        tick();
        run_op("div_m7_0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        tick();
`else
        run_op("mul_op_unsigned", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'h0000_0004);
        tick();
        run_op("div_op_unsigned", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h0000_0001);
        tick();
`endif

        // Start while busy is dropped: first operation completes untouched.
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = 32'd9;
        Operand2 = 32'd11;
        tick();
        Start = 1'b0;
        cyc   = 1;
        repeat (4) begin tick(); cyc++; end
        Start    = 1'b1;
        MCycleOp = 2'b10;
        Operand1 = 32'd100;
        Operand2 = 32'd7;
        tick();
        cyc++;
        Start = 1'b0;
        while (Done !== 1'b1 && cyc < LAT + 20) begin tick(); cyc++; end
        check("busy_start_latency", 32'(cyc), 32'(LAT));
        check("busy_start_result1", Result1, 32'd99);
        check("busy_start_result2", Result2, 32'd0);
        tick();
        tick();

        // Start at cycle 0, ignored Start at cycle 5, RESET at cycle 10.
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = 32'd7;
        Operand2 = 32'd6;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Start    = 1'b1;
        MCycleOp = 2'b10;
        Operand1 = 32'd50;
        Operand2 = 32'd3;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_aluown", 32'(AluOwn), 32'd0);
        check("abort_result1", Result1, 32'd0);
        check("abort_result2", Result2, 32'd0);
        check("abort_srca", AluSrcA, 32'd0);
        check("abort_srcb", AluSrcB, 32'd0);
        check("abort_ctrl", 32'(AluControl), 32'd0);
        dones = 0;
        repeat (LAT + 10) begin
            dones += (Done === 1'b1) ? 1 : 0;
            tick();
        end
        check("abort_no_done", 32'(dones), 32'd0);

        run_op("after_abort_mulu", 2'b00, 32'd3, 32'd5, 32'h0000_000F, 32'h0000_0000);
        tick();
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
